// File: rtl/button_event_fifo.sv
`default_nettype none
// ============================================================================
// button_event_fifo
//   Collects one-cycle button press pulses and queues the button indices in a
//   round-robin-arbitrated first-word-fall-through FIFO.
//   Revision: 1.0
// ============================================================================
module button_event_fifo #(
    parameter int NUM_BTN = 5,
    parameter int DEPTH   = 8,
    parameter int CODE_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_pulse,
    output logic                       ev_valid,
    output logic [CODE_W-1:0]          ev_code,
    input  logic                       ev_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RR_W = $clog2(NUM_BTN);
    localparam logic [RR_W-1:0] LAST_IDX = RR_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] pending;
    logic [RR_W-1:0]    rr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CODE_W-1:0]  mem [DEPTH];

    logic               full;
    logic               pop;
    logic               push;
    logic               found;
    logic [RR_W-1:0]    cand;
    logic [RR_W-1:0]    gnt_idx;
    logic [NUM_BTN-1:0] gnt_vec;
    logic               drop;

    assign full     = (count == CW'(DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    // Empty head reads as zero so the code is deterministic out of reset.
    assign ev_code  = ev_valid ? mem[rd_ptr] : '0;

    // Walk from rr_ptr upward with wrap; the first pending bit wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = rr_ptr;
        for (int k = 0; k < NUM_BTN; k++) begin
            if (!found && pending[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    assign push    = found & ~full;
    assign gnt_vec = push ? (NUM_BTN'(1) << gnt_idx) : '0;
    assign drop    = |(btn_pulse & pending & ~gnt_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            rr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~gnt_vec) | btn_pulse;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag raised.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= CODE_W'(gnt_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_fifo.sv
`default_nettype none
// ============================================================================
// tb_button_event_fifo
//   Directed vector table, async-reset sequence and randomized run against a
//   queue-based reference model.
//   Revision: 1.0
// ============================================================================
module tb_button_event_fifo;

    localparam int NUM_BTN = 5;
    localparam int DEPTH   = 8;
    localparam int CODE_W  = 3;
    localparam int NVEC    = 34;

    logic               clk;
    logic               rst;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               ev_valid;
    logic [CODE_W-1:0]  ev_code;
    logic               ev_ready;
    logic [3:0]         count;
    logic               overflow;
    logic               clr_ovf;

    int checks = 0;
    int errors = 0;

    button_event_fifo #(
        .NUM_BTN (NUM_BTN),
        .DEPTH   (DEPTH),
        .CODE_W  (CODE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ready  (ev_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NUM_BTN-1:0] btn;
        logic               rdy;
        logic               clr;
        logic               exp_valid;
        logic [CODE_W-1:0]  exp_code;
        logic [3:0]         exp_count;
        logic               exp_ovf;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [NUM_BTN-1:0] b, input logic r, input logic c,
                                input logic v, input int code, input int cnt, input logic o);
        vec_t t;
        t.btn = b; t.rdy = r; t.clr = c;
        t.exp_valid = v; t.exp_code = CODE_W'(code); t.exp_count = 4'(cnt); t.exp_ovf = o;
        return t;
    endfunction

    // Reference model: queue of codes plus per-button pending flags.
    int q[$];
    bit m_pend [NUM_BTN];
    int m_rr;
    bit m_ovf;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NUM_BTN; i++) m_pend[i] = 1'b0;
        m_rr  = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [NUM_BTN-1:0] b, input logic r, input logic c);
        bit do_pop;
        bit dropped;
        int g;
        do_pop  = (q.size() > 0) && r;
        dropped = 1'b0;
        g       = -1;
        if (q.size() < DEPTH) begin
            for (int k = 0; k < NUM_BTN; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % NUM_BTN]) g = (m_rr + k) % NUM_BTN;
            end
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            if (b[i] && m_pend[i] && i != g) dropped = 1'b1;
            m_pend[i] = (m_pend[i] && i != g) || b[i];
        end
        if (do_pop) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(g);
            m_rr = (g + 1) % NUM_BTN;
        end
        if (dropped) m_ovf = 1'b1;
        else if (c)  m_ovf = 1'b0;
    endtask

    task automatic step(input logic [NUM_BTN-1:0] b, input logic r, input logic c);
        btn_pulse = b;
        ev_ready  = r;
        clr_ovf   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic v, input int code, input int cnt,
                         input logic o);
        checks++;
        if (ev_valid !== v || ev_code !== CODE_W'(code) || count !== 4'(cnt) || overflow !== o) begin
            errors++;
            $display("FAIL %s: got valid=%0b code=%0d count=%0d ovf=%0b, want valid=%0b code=%0d count=%0d ovf=%0b",
                     name, ev_valid, ev_code, count, overflow, v, code, cnt, o);
        end
    endtask

    task automatic do_reset();
        #3 rst = 1'b0;
        #1 check("reset", 1'b0, 0, 0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_BTN-1:0] rb;
        logic rr, rc;

        // Single/simultaneous presses, round-robin wrap, same-cycle re-press,
        // full FIFO with drop, clear-vs-drop priority and pop at full.
        vecs[0]  = mk(5'b11010, 0, 0, 1, 0, 0, 0);
        vecs[0].exp_valid = 1'b0;
        vecs[1]  = mk(5'b00000, 0, 0, 1, 1, 1, 0);
        vecs[2]  = mk(5'b00000, 0, 0, 1, 1, 2, 0);
        vecs[3]  = mk(5'b00000, 0, 0, 1, 1, 3, 0);
        vecs[4]  = mk(5'b00000, 1, 0, 1, 3, 2, 0);
        vecs[5]  = mk(5'b00000, 1, 0, 1, 4, 1, 0);
        vecs[6]  = mk(5'b00000, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(5'b00100, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(5'b00000, 1, 0, 1, 2, 1, 0);
        vecs[9]  = mk(5'b00000, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(5'b01000, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(5'b00000, 0, 0, 1, 3, 1, 0);
        vecs[12] = mk(5'b00011, 0, 0, 1, 3, 1, 0);
        vecs[13] = mk(5'b00000, 0, 0, 1, 3, 2, 0);
        vecs[14] = mk(5'b00000, 0, 0, 1, 3, 3, 0);
        vecs[15] = mk(5'b00000, 1, 0, 1, 0, 2, 0);
        vecs[16] = mk(5'b00000, 1, 0, 1, 1, 1, 0);
        vecs[17] = mk(5'b00000, 1, 0, 0, 0, 0, 0);
        vecs[18] = mk(5'b11111, 0, 0, 0, 0, 0, 0);
        vecs[19] = mk(5'b00000, 0, 0, 1, 2, 1, 0);
        vecs[20] = mk(5'b00000, 0, 0, 1, 2, 2, 0);
        vecs[21] = mk(5'b00000, 0, 0, 1, 2, 3, 0);
        vecs[22] = mk(5'b00000, 0, 0, 1, 2, 4, 0);
        vecs[23] = mk(5'b00000, 0, 0, 1, 2, 5, 0);
        vecs[24] = mk(5'b00001, 0, 0, 1, 2, 5, 0);
        vecs[25] = mk(5'b00001, 0, 0, 1, 2, 6, 0);
        vecs[26] = mk(5'b00010, 0, 0, 1, 2, 7, 0);
        vecs[27] = mk(5'b00010, 0, 0, 1, 2, 8, 0);
        vecs[28] = mk(5'b00010, 0, 0, 1, 2, 8, 1);
        vecs[29] = mk(5'b00010, 0, 1, 1, 2, 8, 1);
        vecs[30] = mk(5'b00000, 0, 1, 1, 2, 8, 0);
        vecs[31] = mk(5'b00000, 1, 0, 1, 3, 7, 0);
        vecs[32] = mk(5'b00000, 0, 0, 1, 3, 8, 0);
        vecs[33] = mk(5'b00000, 1, 0, 1, 4, 7, 0);

        rst = 1'b0; btn_pulse = '0; ev_ready = 1'b0; clr_ovf = 1'b0;
        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].btn, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].exp_valid, int'(vecs[i].exp_code),
                  int'(vecs[i].exp_count), vecs[i].exp_ovf);
        end

        // Asynchronous reset with queued events, a pending press and overflow set.
        do_reset();
        step(5'b11111, 0, 0);
        step(5'b11111, 0, 0);
        check("pre_rst_ovf", 1'b1, 0, 1, 1'b1);
        for (int i = 0; i < 4; i++) step(5'b00000, 0, 0);
        check("pre_rst_cnt5", 1'b1, 0, 5, 1'b1);
        #3 rst = 1'b0;
        #1 check("async_rst", 1'b0, 0, 0, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        step(5'b01000, 0, 0);
        check("post_rst_e0", 1'b0, 0, 0, 1'b0);
        step(5'b00000, 0, 0);
        check("post_rst_e1", 1'b1, 3, 1, 1'b0);
        step(5'b00000, 1, 0);
        check("post_rst_pop", 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(5'b00000, 1, 0);
            check("post_rst_idle", 1'b0, 0, 0, 1'b0);
        end

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NUM_BTN; i++) rb[i] = ($urandom_range(0, 5) == 0);
            if (cyc < 1500) rr = ($urandom_range(0, 3) == 0);
            else            rr = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 15) == 0);
            model_step(rb, rr, rc);
            step(rb, rr, rc);
            check($sformatf("rand%0d", cyc), q.size() != 0, (q.size() != 0) ? q[0] : 0,
                  q.size(), m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
